// File: rtl/core_pkg.sv
// Shared definitions for the pipelined RISC-V core front end.
// Contents: datapath widths, the canonical NOP encoding and the
// instruction-fetch state encoding used by fetch_unit.
package core_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_DRAIN = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry holding register for an instruction that returned from
// instruction memory while decode was stalled.
// Ports:
//   clk_i, reset_i   clock, synchronous active-high reset
//   load_i           capture {pc_i, instr_i} and mark the entry valid
//   pop_i            entry consumed; mark it empty
//   clear_i          invalidate the entry (highest priority)
//   pc_i, instr_i    entry contents to capture
//   valid_o          entry holds a live instruction
//   pc_o, instr_o    stored entry contents
module fetch_hold_buf
    import core_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            load_i,
    input  logic            pop_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [ILEN-1:0] instr_i,
    output logic            valid_o,
    output logic [XLEN-1:0] pc_o,
    output logic [ILEN-1:0] instr_o
);

    logic            valid_q;
    logic [XLEN-1:0] pc_q;
    logic [ILEN-1:0] instr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= NOP_INSTR;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            instr_q <= instr_i;
        end else if (pop_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign instr_o = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, the instruction-memory request,
// decode-stall handling (via a one-entry hold buffer) and MEM-stage
// branch redirects, and drives the IF/ID pipeline register.
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   imem_req         fetch request; imem_addr valid while high
//   imem_addr        4-byte aligned fetch address (registered PC)
//   imem_rdata       instruction word, valid with imem_ready
//   imem_ready       response for the current imem_addr
//   stall_id         decode cannot accept; IF/ID holds
//   redirect_valid   taken branch from MEM
//   redirect_pc      branch target (bits [1:0] ignored)
//   if_valid         IF/ID holds a live instruction
//   if_pc, if_instr  IF/ID contents (if_instr is NOP when not valid)
module fetch_unit
    import core_pkg::*;
#(
    parameter logic [63:0] PC_RESET = 64'd0
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    input  logic        stall_id,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    output logic [63:0] if_pc,
    output logic [31:0] if_instr
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pending_pc_q, pending_pc_d;
    logic            if_valid_q, if_valid_d;
    logic [XLEN-1:0] if_pc_q, if_pc_d;
    logic [ILEN-1:0] if_instr_q, if_instr_d;

    logic            hb_load, hb_pop, hb_clear;
    logic            hb_valid;
    logic [XLEN-1:0] hb_pc;
    logic [ILEN-1:0] hb_instr;

    logic [XLEN-1:0] redirect_aligned;
    logic [XLEN-1:0] pc_plus4;

    assign redirect_aligned = redirect_pc & ~64'h3;
    assign pc_plus4         = pc_q + 64'd4;   // wraps modulo 2^64

    fetch_hold_buf u_hold (
        .clk_i   (clk),
        .reset_i (reset),
        .load_i  (hb_load),
        .pop_i   (hb_pop),
        .clear_i (hb_clear),
        .pc_i    (pc_q),
        .instr_i (imem_rdata),
        .valid_o (hb_valid),
        .pc_o    (hb_pc),
        .instr_o (hb_instr)
    );

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        pending_pc_d = pending_pc_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;
        hb_load      = 1'b0;
        hb_pop       = 1'b0;
        hb_clear     = 1'b0;

        if (redirect_valid) begin
            if_valid_d = 1'b0;
            hb_clear   = 1'b1;
            // An outstanding request cannot be withdrawn, so its response
            // is drained before the target is fetched.
            if ((state_q == S_FETCH && !imem_ready) || state_q == S_DRAIN) begin
                pending_pc_d = redirect_aligned;
                state_d      = S_DRAIN;
            end else begin
                pc_d    = redirect_aligned;
                state_d = S_FETCH;
            end
        end else begin
            case (state_q)
                S_START: begin
                    state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        pc_d = pc_plus4;
                        if (!stall_id) begin
                            if_valid_d = 1'b1;
                            if_pc_d    = pc_q;
                            if_instr_d = imem_rdata;
                        end else begin
                            hb_load = 1'b1;
                            state_d = S_HOLD;
                        end
                    end else if (!stall_id) begin
                        if_valid_d = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!stall_id && hb_valid) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = hb_pc;
                        if_instr_d = hb_instr;
                        hb_pop     = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_ready) begin
                        pc_d    = pending_pc_q;
                        state_d = S_FETCH;
                    end
                end
                default: begin
                    state_d = S_START;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_START;
            pc_q         <= PC_RESET;
            pending_pc_q <= PC_RESET;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pending_pc_q <= pending_pc_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign imem_addr = pc_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_valid_q ? if_instr_q : NOP_INSTR;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: table-driven cycle vectors for the stall and
// zero-latency redirect paths, hand sequences for multi-cycle memory
// redirects, redirect-during-hold and reset-during-drain, a scoreboard of
// instructions consumed by decode, and a second instance for PC wrap.
module tb_fetch_unit;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        stall_id;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        if_valid;
    logic [63:0] if_pc;
    logic [31:0] if_instr;

    logic        imem_req2;
    logic [63:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic        if_valid2;
    logic [63:0] if_pc2;
    logic [31:0] if_instr2;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    int unsigned lat      = 0;
    int unsigned wait_cnt = 0;
    int unsigned fetch10  = 0;

    logic [63:0] exp_q[$];
    logic        sb_en = 1'b0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return {a[31:2], 2'b11} ^ 32'h5A00_0000;
    endfunction

    // Memory: responds once the address has been requested for lat cycles.
    assign imem_ready  = imem_req && (wait_cnt >= lat);
    assign imem_rdata  = instr_of(imem_addr);
    assign imem_rdata2 = instr_of(imem_addr2);

    always @(posedge clk) begin
        if (!imem_req || imem_ready) wait_cnt <= 0;
        else                         wait_cnt <= wait_cnt + 1;
        if (imem_req && imem_ready && imem_addr == 64'h10) fetch10 <= fetch10 + 1;
    end

    fetch_unit #(.PC_RESET(64'd0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .stall_id(stall_id), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr)
    );

    fetch_unit #(.PC_RESET(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .imem_ready(1'b1),
        .stall_id(1'b0), .redirect_valid(1'b0),
        .redirect_pc(64'd0),
        .if_valid(if_valid2), .if_pc(if_pc2), .if_instr(if_instr2)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Inputs change at posedge+1; the scoreboard samples at the negedge,
    // when an instruction presented with stall_id low is taken by decode.
    task automatic tick();
        logic [63:0] e;
        @(negedge clk);
        if (sb_en && !reset && if_valid && !stall_id) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_pc", if_pc, 64'hDEAD_DEAD_DEAD_DEAD);
            end else begin
                e = exp_q.pop_front();
                check("sb_pc", if_pc, e);
                check("sb_instr", {32'd0, if_instr}, {32'd0, instr_of(e)});
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; stall_id = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {63'd0, if_valid}, 64'd0);
        check({tag, "_pc"}, if_pc, 64'd0);
        check({tag, "_instr"}, {32'd0, if_instr}, {32'd0, NOP_INSTR});
        check({tag, "_req"}, {63'd0, imem_req}, 64'd0);
        check({tag, "_addr"}, imem_addr, 64'd0);
    endtask

    task automatic wait_valid(input string tag, input logic [63:0] pc);
        int unsigned n = 0;
        while (!if_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, {63'd0, if_valid}, 64'd1);
        check({tag, "_pc"}, if_pc, pc);
        check({tag, "_instr"}, {32'd0, if_instr}, {32'd0, instr_of(pc)});
    endtask

    typedef struct {
        logic        stall;
        logic        redir;
        logic [63:0] rpc;
        logic        exp_valid;
        logic [63:0] exp_pc;
        logic        exp_req;
        logic [63:0] exp_addr;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(input logic s, input logic r, input logic [63:0] rp,
                                input logic v, input logic [63:0] p,
                                input logic rq, input logic [63:0] ad);
        vec_t x;
        x.stall = s; x.redir = r; x.rpc = rp;
        x.exp_valid = v; x.exp_pc = p; x.exp_req = rq; x.exp_addr = ad;
        return x;
    endfunction

    initial begin
        int unsigned f10_before;
        logic [31:0] exp_instr;

        // Zero-latency memory: stream, 3-cycle stall over 0x10, redirect.
        vecs[0]  = mk(0, 0, 0,     0, 64'h00, 1, 64'h00);
        vecs[1]  = mk(0, 0, 0,     1, 64'h00, 1, 64'h04);
        vecs[2]  = mk(0, 0, 0,     1, 64'h04, 1, 64'h08);
        vecs[3]  = mk(0, 0, 0,     1, 64'h08, 1, 64'h0C);
        vecs[4]  = mk(0, 0, 0,     1, 64'h0C, 1, 64'h10);
        vecs[5]  = mk(1, 0, 0,     1, 64'h0C, 0, 64'h14);
        vecs[6]  = mk(1, 0, 0,     1, 64'h0C, 0, 64'h14);
        vecs[7]  = mk(1, 0, 0,     1, 64'h0C, 0, 64'h14);
        vecs[8]  = mk(0, 0, 0,     1, 64'h10, 1, 64'h14);
        vecs[9]  = mk(0, 0, 0,     1, 64'h14, 1, 64'h18);
        vecs[10] = mk(0, 0, 0,     1, 64'h18, 1, 64'h1C);
        vecs[11] = mk(0, 1, 64'h83, 0, 64'h18, 1, 64'h80);
        vecs[12] = mk(0, 0, 0,     1, 64'h80, 1, 64'h84);

        lat = 0;
        do_reset();
        check_reset_outputs("reset");
        check("wrap_reset_addr", imem_addr2, 64'hFFFF_FFFF_FFFF_FFFC);

        exp_q = '{64'h00, 64'h04, 64'h08, 64'h0C, 64'h10, 64'h14, 64'h18};
        sb_en = 1'b1;
        f10_before = fetch10;
        for (int i = 0; i < 13; i++) begin
            stall_id       = vecs[i].stall;
            redirect_valid = vecs[i].redir;
            redirect_pc    = vecs[i].rpc;
            tick();
            exp_instr = vecs[i].exp_valid ? instr_of(vecs[i].exp_pc) : NOP_INSTR;
            check($sformatf("vec%0d_valid", i), {63'd0, if_valid}, {63'd0, vecs[i].exp_valid});
            check($sformatf("vec%0d_pc", i), if_pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_instr", i), {32'd0, if_instr}, {32'd0, exp_instr});
            check($sformatf("vec%0d_req", i), {63'd0, imem_req}, {63'd0, vecs[i].exp_req});
            if (vecs[i].exp_req) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            if (i == 1) check("wrap_first_pc", if_pc2, 64'hFFFF_FFFF_FFFF_FFFC);
            if (i == 2) begin
                check("wrap_second_pc", if_pc2, 64'd0);
                check("wrap_second_valid", {63'd0, if_valid2}, 64'd1);
            end
        end
        sb_en = 1'b0;
        redirect_valid = 1'b0;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("fetch_0x10_once", 64'(fetch10 - f10_before), 64'd1);

        // Two-cycle memory, redirect while the first request is pending.
        lat = 2;
        do_reset();
        tick();
        check("drain_pre_addr", imem_addr, 64'h0);
        redirect_valid = 1'b1; redirect_pc = 64'h203;
        tick();
        redirect_valid = 1'b0;
        check("drain_state", {62'd0, dut.state_q}, {62'd0, S_DRAIN});
        check("drain_req", {63'd0, imem_req}, 64'd1);
        check("drain_addr_held", imem_addr, 64'h0);
        tick();
        tick();
        check("drain_new_addr", imem_addr, 64'h200);
        check("drain_data_dropped", {63'd0, if_valid}, 64'd0);
        wait_valid("drain_target", 64'h200);

        // Redirect and stall together while the hold buffer is full.
        lat = 0;
        do_reset();
        tick();
        stall_id = 1'b1;
        tick();
        check("hold_buf_full", {63'd0, dut.u_hold.valid_q}, 64'd1);
        check("hold_req_low", {63'd0, imem_req}, 64'd0);
        redirect_valid = 1'b1; redirect_pc = 64'h40;
        tick();
        redirect_valid = 1'b0; stall_id = 1'b0;
        check("redir_stall_buf_cleared", {63'd0, dut.u_hold.valid_q}, 64'd0);
        check("redir_stall_valid", {63'd0, if_valid}, 64'd0);
        check("redir_stall_addr", imem_addr, 64'h40);
        tick();
        check("redir_stall_pc", if_pc, 64'h40);
        check("redir_stall_valid_after", {63'd0, if_valid}, 64'd1);

        // Reset while draining.
        lat = 2;
        do_reset();
        tick();
        redirect_valid = 1'b1; redirect_pc = 64'h100;
        tick();
        redirect_valid = 1'b0;
        reset = 1'b1;
        tick();
        check_reset_outputs("drain_reset");
        reset = 1'b0;
        tick();
        check("post_reset_req", {63'd0, imem_req}, 64'd1);
        check("post_reset_addr", imem_addr, 64'd0);
        wait_valid("post_reset_first", 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage for the pipelined RISC-V core. It replaces the loose PC register, +4 adder, branch MUX and IF/ID register with one block, and owns the PC, the instruction-memory request, ID-stage stall handling and MEM-stage branch redirects. Its outputs are the IF/ID pipeline register contents, consumed directly by instruction decode, immediate generation and the register file. A one-entry hold buffer lets the stage absorb a returned instruction while decode is stalled, without re-fetching it.

## Interface
- PC_RESET, 64'd0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, instruction presented on if_instr while if_valid is 0 (addi x0,x0,0).
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request; imem_addr is valid while high.
- imem_addr  out  64  fetch address, 4-byte aligned.
- imem_rdata  in  32  instruction word; valid when imem_ready is 1.
- imem_ready  in  1  response for the current imem_addr. It may arrive in the same cycle as the request or N ≥ 1 cycles later.
- stall_id  in  1  decode cannot accept; IF/ID must hold its value.
- redirect_valid  in  1  taken branch resolved in MEM (to_branch_MEM).
- redirect_pc  in  64  branch target; bits [1:0] are ignored and forced to 0.
- if_valid  out  1  IF/ID register holds a live instruction.
- if_pc  out  64  PC of if_instr.
- if_instr  out  32  IF/ID instruction.

## Operation
- State machine: S_START, S_FETCH, S_HOLD, S_DRAIN. Reset enters S_START.
- S_START: imem_req = 0 for one cycle, then go to S_FETCH.
- S_FETCH:
  - imem_req = 1, imem_addr = pc.
  - imem_addr stays constant until imem_ready is seen.
  - On imem_ready with stall_id = 0: load IF/ID with {pc, imem_rdata, valid = 1} and set pc <= pc + 4.
  - On imem_ready with stall_id = 1: IF/ID is unchanged. Write {pc, imem_rdata} into the hold buffer, set pc <= pc + 4, go to S_HOLD.
  - No imem_ready while stall_id = 0: clear if_valid (bubble).
  - No imem_ready while stall_id = 1: IF/ID is unchanged.
- S_HOLD:
  - imem_req = 0.
  - When stall_id = 0: move the buffer into IF/ID with valid = 1, go to S_FETCH.
- S_DRAIN: a request is in flight whose data must be discarded.
  - imem_req stays 1 and imem_addr holds the old address.
  - On imem_ready: drop the data, set pc <= pending_pc, go to S_FETCH.
- Redirect has priority over stall and over everything else. In the cycle redirect_valid = 1:
  - if_valid <= 0 and the hold buffer is invalidated.
  - If in S_FETCH without imem_ready, or in S_DRAIN: pending_pc <= redirect_pc and go to S_DRAIN (a newer redirect overwrites pending_pc).
  - Otherwise: pc <= redirect_pc and go to S_FETCH.
- pc + 4 arithmetic is 64-bit modulo; 0xFFFF_FFFF_FFFF_FFFC wraps to 0.
- if_instr = NOP_INSTR whenever if_valid = 0. if_pc keeps its last value.

## Timing
- Reset values:
  - if_valid = 0, if_pc = 0, if_instr = NOP_INSTR.
  - imem_req = 0, imem_addr = PC_RESET.
  - pc = PC_RESET, hold buffer empty.
- Reset asserted mid-request (S_FETCH or S_DRAIN) abandons the request. The memory must tolerate imem_req dropping.
- With a zero-latency memory (imem_ready tied to 1) and no stalls, throughput is one instruction per cycle.
- Latency from the first post-reset edge:
  - S_START occupies one cycle.
  - if_valid first rises at the second edge after reset deasserts, with if_pc = PC_RESET.
- With a zero-latency memory, redirect_valid at edge k makes IF/ID hold redirect_pc at edge k+1 (if_valid = 0 at k, then 1 at k+1).
- imem_addr is registered (driven from pc), never combinational from redirect_pc.

## Structure
- Shared package (core_pkg):
  - fetch state enum (2 bits).
  - NOP_INSTR constant.
  - XLEN = 64, ILEN = 32.
- One sub-module: fetch_hold_buf. It is a single-entry {pc, instr, valid} register with load, pop and clear inputs. Everything else lives in fetch_unit.

## Test plan
- Zero-latency memory, no stall, PC_RESET = 0 → if_pc sequence is 0, 4, 8, 12 on consecutive cycles, with if_valid = 1 from cycle 2.
- stall_id high for 3 cycles while an instruction at 0x10 returns:
  - IF/ID holds 0x0C throughout the stall.
  - imem_req = 0 while in S_HOLD.
  - One cycle after the stall drops, IF/ID = {0x10, instr}.
  - 0x10 is fetched exactly once.
- Memory with 2-cycle latency, redirect_valid with redirect_pc = 0x203 during the wait:
  - State goes to S_DRAIN.
  - The old data is discarded.
  - The next imem_addr is 0x200.
  - if_pc = 0x200 after that response.
- redirect_valid and stall_id asserted in the same cycle, with the hold buffer full:
  - Buffer is cleared and if_valid = 0.
  - The next fetch is from redirect_pc.
- PC_RESET = 64'hFFFF_FFFF_FFFF_FFFC with a zero-latency memory → second if_pc = 0 (wrap).
- reset asserted in S_DRAIN → all outputs take their reset values at the next edge, and the first fetch after release is from PC_RESET.
